regfile_sequencer: RTL and testbench

- Multi-cycle controller that executes one register-level command at a time against the 4x10-bit register file (write port WRA/ENW/D on Clkb; combinational read ports RDA0/ENR0->Q0 and RDA1/ENR1->Q1).
- Sequences operand read, ALU handshake and writeback.
- Sits between the instruction decoder (command valid/ready) and the register file plus ALU.

---
 rtl/regfile_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle controller that runs one register-level
// command at a time (LOAD / MOV / ALU / NOP) against an external 4-entry
// register file and an external ALU.
//
// Handshakes (valid/ready):
//   Command side: a command transfers on a rising edge where Cmd_valid and
//   Cmd_ready are both 1. Cmd_ready is high only while IDLE. All command
//   fields are latched on that edge. Inputs seen while Cmd_ready is 0 are
//   ignored. The ALU side follows the same rule: operands transfer on an edge
//   where Alu_valid and Alu_ready are both 1. Alu_a, Alu_b and Alu_fn stay
//   stable while Alu_valid waits for Alu_ready. The result comes back later as
//   a one-cycle Alu_done strobe, which is only listened to in WAIT.
//
// Every output comes straight from a flop, so an asynchronous reset drops
// them immediately. A write that is pending when reset hits never happens.

module regfile_sequencer #(
   parameter int DW      = 10,
   parameter int TIMEOUT = 15,
   parameter int TW      = 4
) (
   input  logic          Clkb,
   input  logic          Resetn,
   // command interface from the decoder
   input  logic          Cmd_valid,
   output logic          Cmd_ready,
   input  logic [1:0]    Cmd_op,
   input  logic [1:0]    Cmd_rx,
   input  logic [1:0]    Cmd_ry,
   input  logic [2:0]    Cmd_fn,
   input  logic [DW-1:0] Cmd_imm,
   // register file write port
   output logic [1:0]    WRA,
   output logic          ENW,
   output logic [DW-1:0] D,
   // register file read ports
   output logic [1:0]    RDA0,
   output logic          ENR0,
   output logic [1:0]    RDA1,
   output logic          ENR1,
   input  logic [DW-1:0] Q0,
   input  logic [DW-1:0] Q1,
   // ALU interface
   output logic          Alu_valid,
   input  logic          Alu_ready,
   output logic [2:0]    Alu_fn,
   output logic [DW-1:0] Alu_a,
   output logic [DW-1:0] Alu_b,
   input  logic          Alu_done,
   input  logic [DW-1:0] Alu_result,
   // status
   output logic          Done,
   output logic          Err,
   output logic          Busy,
   // current FSM state, for observation only
   output logic [2:0]    o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WRITE = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_MOV  = 2'b01,
      OP_ALU  = 2'b10,
      OP_NOP  = 2'b11
   } op_e;

   // Last WAIT count value: reaching it without Alu_done means TIMEOUT
   // WAIT cycles have elapsed.
   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

   state_e        r_state;
   op_e           r_op;
   logic [1:0]    r_rx;
   logic [TW-1:0] r_cnt;

   logic          r_cmd_ready;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   logic [1:0]    r_wra;
   logic          r_enw;
   logic [DW-1:0] r_d;

   logic [1:0]    r_rda0;
   logic          r_enr0;
   logic [1:0]    r_rda1;
   logic          r_enr1;

   logic          r_alu_valid;
   logic [2:0]    r_alu_fn;
   logic [DW-1:0] r_alu_a;
   logic [DW-1:0] r_alu_b;

   logic          w_accept;
   logic          w_alu_xfer;
   logic          w_timeout;

   assign w_accept   = Cmd_valid & r_cmd_ready;
   assign w_alu_xfer = r_alu_valid & Alu_ready;
   assign w_timeout  = (r_cnt == CNT_LAST);

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge Clkb or negedge Resetn) begin
      if (!Resetn) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_LOAD;
         r_rx        <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_wra       <= '0;
         r_enw       <= 1'b0;
         r_d         <= '0;
         r_rda0      <= '0;
         r_enr0      <= 1'b0;
         r_rda1      <= '0;
         r_enr1      <= 1'b0;
         r_alu_valid <= 1'b0;
         r_alu_fn    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
      end else begin
         // status strobes are single-cycle unless re-armed below
         r_done <= 1'b0;
         r_err  <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               // Ready rises on the first edge after reset release and stays
               // up for as long as the sequencer idles.
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  r_op     <= op_e'(Cmd_op);
                  r_rx     <= Cmd_rx;
                  r_alu_fn <= Cmd_fn;
                  case (op_e'(Cmd_op))
                     OP_LOAD: begin
                        // immediate goes straight to the write port
                        r_state     <= ST_WRITE;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_enw       <= 1'b1;
                        r_wra       <= Cmd_rx;
                        r_d         <= Cmd_imm;
                     end
                     OP_MOV, OP_ALU: begin
                        r_state     <= ST_READ;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_rda0      <= Cmd_rx;
                        r_rda1      <= Cmd_ry;
                        r_enr0      <= 1'b1;
                        r_enr1      <= 1'b1;
                     end
                     default: begin
                        // NOP retires on the spot
                        r_done <= 1'b1;
                     end
                  endcase
               end
            end

            ST_READ: begin
               // Both operands are captured; the read ports close again.
               r_enr0  <= 1'b0;
               r_enr1  <= 1'b0;
               r_alu_a <= Q0;
               r_alu_b <= Q1;
               if (r_op == OP_MOV) begin
                  r_state <= ST_WRITE;
                  r_enw   <= 1'b1;
                  r_wra   <= r_rx;
                  r_d     <= Q1;
               end else begin
                  r_state     <= ST_EXEC;
                  r_alu_valid <= 1'b1;
               end
            end

            ST_EXEC: begin
               // No timeout here: the ALU may hold off ready as long as it likes.
               if (w_alu_xfer) begin
                  r_state     <= ST_WAIT;
                  r_alu_valid <= 1'b0;
                  r_cnt       <= '0;
               end
            end

            ST_WAIT: begin
               // Alu_done is checked before the timeout, so a result on the
               // last allowed cycle still counts as success.
               if (Alu_done) begin
                  r_state <= ST_WRITE;
                  r_enw   <= 1'b1;
                  r_wra   <= r_rx;
                  r_d     <= Alu_result;
               end else if (w_timeout) begin
                  r_state     <= ST_IDLE;
                  r_err       <= 1'b1;
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + TW'(1);
               end
            end

            ST_WRITE: begin
               // The register file takes D on this closing edge.
               r_state     <= ST_IDLE;
               r_enw       <= 1'b0;
               r_done      <= 1'b1;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
            end

            default: begin
               r_state     <= ST_IDLE;
               r_enw       <= 1'b0;
               r_enr0      <= 1'b0;
               r_enr1      <= 1'b0;
               r_alu_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign Cmd_ready   = r_cmd_ready;
   assign WRA         = r_wra;
   assign ENW         = r_enw;
   assign D           = r_d;
   assign RDA0        = r_rda0;
   assign ENR0        = r_enr0;
   assign RDA1        = r_rda1;
   assign ENR1        = r_enr1;
   assign Alu_valid   = r_alu_valid;
   assign Alu_fn      = r_alu_fn;
   assign Alu_a       = r_alu_a;
   assign Alu_b       = r_alu_b;
   assign Done        = r_done;
   assign Err         = r_err;
   assign Busy        = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed testbench for regfile_sequencer: a behavioural 4x10 register
// file and a hand-driven ALU surround the DUT; every expected value is
// written out by hand from the command sequence.

module tb_regfile_sequencer;

   localparam int DW = 10;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;

   logic          Clkb;
   logic          Resetn;
   logic          Cmd_valid;
   logic          Cmd_ready;
   logic [1:0]    Cmd_op;
   logic [1:0]    Cmd_rx;
   logic [1:0]    Cmd_ry;
   logic [2:0]    Cmd_fn;
   logic [DW-1:0] Cmd_imm;
   logic [1:0]    WRA;
   logic          ENW;
   logic [DW-1:0] D;
   logic [1:0]    RDA0;
   logic          ENR0;
   logic [1:0]    RDA1;
   logic          ENR1;
   logic [DW-1:0] Q0;
   logic [DW-1:0] Q1;
   logic          Alu_valid;
   logic          Alu_ready;
   logic [2:0]    Alu_fn;
   logic [DW-1:0] Alu_a;
   logic [DW-1:0] Alu_b;
   logic          Alu_done;
   logic [DW-1:0] Alu_result;
   logic          Done;
   logic          Err;
   logic          Busy;
   logic [2:0]    o_dbg_state;

   int total = 0;
   int bad   = 0;

   // expected register-file writes as {WRA, D}
   logic [11:0] exp_q[$];

   logic [DW-1:0] rf [4] = '{default: '0};

   regfile_sequencer #(.DW(DW), .TIMEOUT(15), .TW(4)) dut (
      .Clkb        (Clkb),
      .Resetn      (Resetn),
      .Cmd_valid   (Cmd_valid),
      .Cmd_ready   (Cmd_ready),
      .Cmd_op      (Cmd_op),
      .Cmd_rx      (Cmd_rx),
      .Cmd_ry      (Cmd_ry),
      .Cmd_fn      (Cmd_fn),
      .Cmd_imm     (Cmd_imm),
      .WRA         (WRA),
      .ENW         (ENW),
      .D           (D),
      .RDA0        (RDA0),
      .ENR0        (ENR0),
      .RDA1        (RDA1),
      .ENR1        (ENR1),
      .Q0          (Q0),
      .Q1          (Q1),
      .Alu_valid   (Alu_valid),
      .Alu_ready   (Alu_ready),
      .Alu_fn      (Alu_fn),
      .Alu_a       (Alu_a),
      .Alu_b       (Alu_b),
      .Alu_done    (Alu_done),
      .Alu_result  (Alu_result),
      .Done        (Done),
      .Err         (Err),
      .Busy        (Busy),
      .o_dbg_state (o_dbg_state)
   );

   // clock
   initial Clkb = 1'b0;
   always #5 Clkb = ~Clkb;

   // register file model: synchronous write, combinational gated read
   always @(posedge Clkb) begin
      if (ENW) rf[WRA] <= D;
   end
   assign Q0 = ENR0 ? rf[RDA0] : 'z;
   assign Q1 = ENR1 ? rf[RDA1] : 'z;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // write scoreboard: every ENW seen mid-cycle must match the next expected write
   always @(negedge Clkb) begin
      if (Resetn && ENW) begin
         if (exp_q.size() == 0) check_val("unexpected_write", {20'd0, WRA, D}, 32'hFFF);
         else check_val("write", {20'd0, WRA, D}, {20'd0, exp_q.pop_front()});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clkb);
         #1;
      end
   endtask

   // present a command for one edge; on return we are in cycle 1 after accept
   task automatic issue(input logic [1:0] op, input logic [1:0] rx, input logic [1:0] ry,
                        input logic [2:0] fn, input logic [DW-1:0] imm);
      check_val("ready_at_issue", Cmd_ready, 1);
      Cmd_valid = 1'b1;
      Cmd_op    = op;
      Cmd_rx    = rx;
      Cmd_ry    = ry;
      Cmd_fn    = fn;
      Cmd_imm   = imm;
      step(1);
      Cmd_valid = 1'b0;
      Cmd_imm   = '0;
   endtask

   task automatic do_load(input logic [1:0] rx, input logic [DW-1:0] imm);
      exp_q.push_back({rx, imm});
      issue(2'b00, rx, 2'd0, 3'd0, imm);
      step(1);
      check_val("load_done", Done, 1);
   endtask

   // reset pulse placed between edges; called 1ns after a rising edge
   task automatic async_reset(input string tag);
      Resetn = 1'b0;
      #1;
      check_val({tag, "_enw"}, ENW, 0);
      check_val({tag, "_alu_valid"}, Alu_valid, 0);
      check_val({tag, "_busy"}, Busy, 0);
      check_val({tag, "_ready"}, Cmd_ready, 0);
      check_val({tag, "_state"}, o_dbg_state, S_IDLE);
      #1;
      Resetn = 1'b1;
      step(1);
      check_val({tag, "_ready_after"}, Cmd_ready, 1);
   endtask

   initial begin
      Resetn     = 1'b0;
      Cmd_valid  = 1'b0;
      Cmd_op     = '0;
      Cmd_rx     = '0;
      Cmd_ry     = '0;
      Cmd_fn     = '0;
      Cmd_imm    = '0;
      Alu_ready  = 1'b1;
      Alu_done   = 1'b0;
      Alu_result = '0;

      // reset state
      step(3);
      check_val("rst_ready", Cmd_ready, 0);
      check_val("rst_busy", Busy, 0);
      check_val("rst_enw", ENW, 0);
      check_val("rst_done", Done, 0);
      check_val("rst_err", Err, 0);
      check_val("rst_alu_valid", Alu_valid, 0);
      check_val("rst_enr", {ENR0, ENR1}, 0);
      #2;
      Resetn = 1'b1;
      step(1);
      check_val("ready_after_rst", Cmd_ready, 1);
      check_val("busy_after_rst", Busy, 0);

      // LOAD r2 = 0x2A5
      exp_q.push_back({2'd2, 10'h2A5});
      issue(2'b00, 2'd2, 2'd0, 3'd0, 10'h2A5);
      check_val("load_enw", ENW, 1);
      check_val("load_wra", WRA, 2);
      check_val("load_d", D, 10'h2A5);
      check_val("load_busy", Busy, 1);
      check_val("load_ready", Cmd_ready, 0);
      check_val("load_done_early", Done, 0);
      step(1);
      check_val("load_done", Done, 1);
      check_val("load_enw_off", ENW, 0);
      check_val("load_rf2", rf[2], 10'h2A5);

      // ALU r1 = r1 fn5 r3
      do_load(2'd1, 10'h00F);
      do_load(2'd3, 10'h3F0);
      exp_q.push_back({2'd1, 10'h3FF});
      issue(2'b10, 2'd1, 2'd3, 3'd5, 10'h000);
      check_val("alu_state_read", o_dbg_state, S_READ);
      check_val("alu_rda0", RDA0, 1);
      check_val("alu_rda1", RDA1, 3);
      check_val("alu_enr", {ENR0, ENR1}, 2'b11);
      step(1);
      check_val("alu_valid", Alu_valid, 1);
      check_val("alu_a", Alu_a, 10'h00F);
      check_val("alu_b", Alu_b, 10'h3F0);
      check_val("alu_fn", Alu_fn, 5);
      check_val("alu_enr_off", {ENR0, ENR1}, 0);
      step(1);
      check_val("alu_state_wait", o_dbg_state, S_WAIT);
      check_val("alu_valid_off", Alu_valid, 0);
      step(1);
      Alu_done   = 1'b1;
      Alu_result = 10'h3FF;
      step(1);
      Alu_done   = 1'b0;
      Alu_result = '0;
      check_val("alu_wr_enw", ENW, 1);
      check_val("alu_wr_d", D, 10'h3FF);
      check_val("alu_done_early", Done, 0);
      step(1);
      check_val("alu_done", Done, 1);
      check_val("alu_rf1", rf[1], 10'h3FF);

      // MOV r0 <- r1 with r1 = 0x155
      do_load(2'd1, 10'h155);
      exp_q.push_back({2'd0, 10'h155});
      issue(2'b01, 2'd0, 2'd1, 3'd0, 10'h000);
      check_val("mov_enr", {ENR0, ENR1}, 2'b11);
      step(1);
      check_val("mov_state", o_dbg_state, S_WRITE);
      check_val("mov_wra", WRA, 0);
      check_val("mov_d", D, 10'h155);
      check_val("mov_enr_off", {ENR0, ENR1}, 0);
      step(1);
      check_val("mov_done", Done, 1);
      check_val("mov_rf0", rf[0], 10'h155);
      check_val("mov_enr_idle", {ENR0, ENR1}, 0);

      // ALU r3 fn2 r0 with no Alu_done: timeout after 15 WAIT cycles
      issue(2'b10, 2'd3, 2'd0, 3'd2, 10'h000);
      step(1);
      check_val("to_alu_a", Alu_a, 10'h3F0);
      check_val("to_alu_b", Alu_b, 10'h155);
      step(15);
      check_val("to_err_early", Err, 0);
      check_val("to_busy_wait15", Busy, 1);
      step(1);
      check_val("to_err", Err, 1);
      check_val("to_done", Done, 0);
      check_val("to_ready", Cmd_ready, 1);
      check_val("to_busy", Busy, 0);
      step(1);
      check_val("to_err_pulse", Err, 0);
      check_val("to_rf3", rf[3], 10'h3F0);

      // same command, Alu_done on WAIT cycle 15
      exp_q.push_back({2'd3, 10'h123});
      issue(2'b10, 2'd3, 2'd0, 3'd2, 10'h000);
      step(16);
      Alu_done   = 1'b1;
      Alu_result = 10'h123;
      step(1);
      Alu_done   = 1'b0;
      Alu_result = '0;
      check_val("d15_enw", ENW, 1);
      check_val("d15_err", Err, 0);
      step(1);
      check_val("d15_done", Done, 1);
      check_val("d15_err2", Err, 0);
      check_val("d15_rf3", rf[3], 10'h123);

      // reset during an EXEC stall
      Alu_ready = 1'b0;
      issue(2'b10, 2'd2, 2'd1, 3'd3, 10'h000);
      step(2);
      check_val("stall_valid", Alu_valid, 1);
      check_val("stall_alu_a", Alu_a, 10'h2A5);
      async_reset("rst_exec");
      Alu_ready = 1'b1;

      // reset during WAIT
      issue(2'b10, 2'd2, 2'd1, 3'd3, 10'h000);
      step(2);
      check_val("rw_state", o_dbg_state, S_WAIT);
      async_reset("rst_wait");
      check_val("rw_rf2", rf[2], 10'h2A5);

      // reset during WRITE
      issue(2'b00, 2'd2, 2'd0, 3'd0, 10'h3C3);
      check_val("rwr_enw", ENW, 1);
      async_reset("rst_write");
      check_val("rwr_rf2", rf[2], 10'h2A5);

      // back-to-back: ALU issued in the Done cycle of a LOAD reads the new value
      do_load(2'd2, 10'h001);
      exp_q.push_back({2'd2, 10'h002});
      issue(2'b10, 2'd2, 2'd2, 3'd1, 10'h000);
      check_val("b2b_rda", {RDA0, RDA1}, 4'b1010);
      step(1);
      check_val("b2b_alu_a", Alu_a, 10'h001);
      check_val("b2b_alu_b", Alu_b, 10'h001);
      step(1);
      Alu_done   = 1'b1;
      Alu_result = 10'h002;
      step(1);
      Alu_done   = 1'b0;
      Alu_result = '0;
      step(1);
      check_val("b2b_done", Done, 1);
      check_val("b2b_rf2", rf[2], 10'h002);

      // NOP: Done next cycle, never busy
      issue(2'b11, 2'd1, 2'd1, 3'd0, 10'h000);
      check_val("nop_done", Done, 1);
      check_val("nop_busy", Busy, 0);
      check_val("nop_ready", Cmd_ready, 1);
      step(1);
      check_val("nop_done_pulse", Done, 0);
      check_val("nop_rf1", rf[1], 10'h155);

      step(2);
      check_val("writes_left", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
